// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding CPU-to-RAM controller for a 16-bit word RAM.
// Converts byte addresses to word addresses and does byte stores as read-modify-write.
// Rejects misaligned word accesses and out-of-range addresses with a one-cycle error response.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready      CPU request handshake (ready only while idle)
//   req_addr/wdata/we/byte   byte address, store data, store flag, byte-access flag
//   resp_valid               one-cycle completion pulse
//   resp_rdata/resp_err      registered load result / error flag, held until next response
//   ram_addr/din/be/we       RAM word address, write data, byte enables, write strobe
//   ram_dout                 RAM read data, one cycle after ram_addr is sampled
module mem_ctrl #(
    parameter int unsigned ADDR_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_we,
    input  logic        req_byte,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_din,
    output logic [1:0]  ram_be,
    output logic        ram_we,
    input  logic [15:0] ram_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StResp
    } state_t;

    // 17 bits so the comparison against a full 15-bit word index never wraps.
    localparam logic [16:0] LP_WORDS = 17'(ADDR_WORDS);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata_lo;
    logic        r_we;
    logic        r_byte;
    logic [15:0] r_din;
    logic [15:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_err;
    logic [15:0] w_load_data;
    logic [15:0] w_merge;
    logic [15:0] w_resp_rdata;

    assign w_accept = req_valid && (r_state == StIdle);
    assign w_err    = (!req_byte && req_addr[0]) || ({2'b00, req_addr[15:1]} >= LP_WORDS);

    // Even byte address is the high byte of the word.
    assign w_load_data = !r_byte   ? ram_dout :
                         r_addr[0] ? {8'h00, ram_dout[7:0]} : {8'h00, ram_dout[15:8]};
    assign w_merge     = r_addr[0] ? {ram_dout[15:8], r_wdata_lo} : {r_wdata_lo, ram_dout[7:0]};

    // Only a load leaving CAP carries data; errors and stores respond with zero.
    assign w_resp_rdata = (r_state == StCap && !r_we) ? w_load_data : 16'h0000;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_next = StResp;
                    end else if (req_we && !req_byte) begin
                        w_state_next = StWr;
                    end else begin
                        w_state_next = StRd;
                    end
                end
            end
            StRd:   w_state_next = StCap;
            StCap:  w_state_next = (r_we && r_byte) ? StWr : StResp;
            StWr:   w_state_next = StResp;
            StResp: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_addr       <= 16'h0000;
            r_wdata_lo   <= 8'h00;
            r_we         <= 1'b0;
            r_byte       <= 1'b0;
            r_din        <= 16'h0000;
            r_resp_rdata <= 16'h0000;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_wdata_lo <= req_wdata[7:0];
                r_we       <= req_we;
                r_byte     <= req_byte;
                r_din      <= req_wdata;
            end
            // Byte store: fold the new byte into the word just read back.
            if (r_state == StCap && r_we) begin
                r_din <= w_merge;
            end
            if (w_state_next == StResp) begin
                r_resp_rdata <= w_resp_rdata;
                r_resp_err   <= (r_state == StIdle);
            end
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = (r_state == StResp);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign ram_addr   = {1'b0, r_addr[15:1]};
    assign ram_din    = r_din;
    assign ram_be     = 2'b11;
    // Gated by reset so a reset landing in WR cancels the write.
    assign ram_we     = (r_state == StWr) && !reset;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: behavioural RAM model, directed requests, scoreboard of expected
// responses checked by an independent monitor (data, error flag and acceptance-to-response latency).
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_we;
    logic        req_byte;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_be;
    logic        ram_we;
    logic [15:0] ram_dout;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_be     (ram_be),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    // Synchronous-read RAM model, 256 words.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr[7:0]];
        if (ram_we) mem[ram_addr[7:0]] <= ram_din;
    end

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    logic no_wr   = 1'b0;
    logic wr_seen = 1'b0;
    exp_t mon_e;
    int   mon_a;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: records acceptances, compares every response against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            acc_q.delete();
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (no_wr && ram_we) wr_seen = 1'b1;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    chk16("resp_rdata", resp_rdata, mon_e.rdata);
                    chk16("resp_err", {15'b0, resp_err}, {15'b0, mon_e.err});
                    chk16("latency", 16'(cyc - mon_a), 16'(mon_e.lat));
                end
            end
        end
    end

    // Present a request and return at the negedge just before its acceptance edge.
    task automatic issue(input logic [15:0] addr, input logic [15:0] wdata, input logic we,
                         input logic bt, input logic push, input logic [15:0] erd,
                         input logic eerr, input int lat);
        exp_t e;
        @(posedge clk); #1;
        req_addr  = addr;
        req_wdata = wdata;
        req_we    = we;
        req_byte  = bt;
        req_valid = 1'b1;
        if (push) begin
            e.rdata = erd;
            e.err   = eerr;
            e.lat   = lat;
            exp_q.push_back(e);
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 (addr %h)", addr);
        end
    endtask

    // Drop req_valid after the pending acceptance and wait for all expected responses.
    task automatic drain();
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk16("rst_ready", {15'b0, req_ready}, 16'h0001);
        chk16("rst_resp_valid", {15'b0, resp_valid}, 16'h0000);
        chk16("rst_resp_rdata", resp_rdata, 16'h0000);
        chk16("rst_resp_err", {15'b0, resp_err}, 16'h0000);
        chk16("rst_ram_addr", ram_addr, 16'h0000);
        chk16("rst_ram_din", ram_din, 16'h0000);
        chk16("rst_ram_we", {15'b0, ram_we}, 16'h0000);
        chk16("ram_be", {14'b0, ram_be}, 16'h0003);
        @(posedge clk); #1;
        reset = 1'b0;

        // Word store then word load.
        issue(16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 2);
        issue(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 3);
        drain();
        chk16("mem8_word", mem[8], 16'hBEEF);

        // Byte store to odd byte, byte loads of both halves.
        issue(16'h0011, 16'h0042, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 4);
        drain();
        chk16("mem8_odd_byte", mem[8], 16'hBE42);
        issue(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00BE, 1'b0, 3);
        issue(16'h0011, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b0, 3);
        drain();

        // Byte store to even byte.
        issue(16'h0010, 16'h0055, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 4);
        drain();
        chk16("mem8_even_byte", mem[8], 16'h5542);

        // Misaligned word load and out-of-range word store: no RAM write allowed.
        no_wr = 1'b1;
        issue(16'h0011, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1);
        issue(16'h0200, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1);
        drain();
        no_wr = 1'b0;
        chk16("err_no_ram_we", {15'b0, wr_seen}, 16'h0000);
        chk16("err_hold", {15'b0, resp_err}, 16'h0001);
        chk16("rdata_hold", resp_rdata, 16'h0000);

        // Preload word 9, then reset during the WR of a byte store to it.
        issue(16'h0012, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 2);
        drain();
        issue(16'h0012, 16'h0077, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0);
        @(posedge clk); #1;   // accepted, now RD
        req_valid = 1'b0;
        @(posedge clk); #1;   // CAP
        @(posedge clk); #1;   // WR
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk16("post_rst_ready", {15'b0, req_ready}, 16'h0001);
        chk16("post_rst_ram_addr", ram_addr, 16'h0000);
        chk16("post_rst_ram_din", ram_din, 16'h0000);
        chk16("post_rst_resp_err", {15'b0, resp_err}, 16'h0000);
        repeat (6) @(negedge clk);
        chk16("mem9_unchanged", mem[9], 16'h1234);

        // Four back-to-back loads with req_valid held high.
        issue(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5542, 1'b0, 3);
        issue(16'h0012, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 3);
        issue(16'h0011, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b0, 3);
        issue(16'h0013, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0034, 1'b0, 3);
        drain();
        chk16("acc_q_empty", 16'(acc_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
